// File: rtl/pair_accum_stage.sv
// pair_accum_stage: consumer for a dual-output datapath stage.
// Incoming (a, b) result pairs are buffered in a small FIFO. N pairs are
// accumulated into one batch: the sum of a+b and the count of pairs with
// a == b. Each completed batch is presented on a valid/ready port.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   in_valid_i   in_a_i/in_b_i hold a valid pair
//   in_ready_o   FIFO can accept a pair (FIFO not full)
//   in_a_i       first operand, W bits
//   in_b_i       second operand, W bits
//   out_valid_o  batch result available
//   out_ready_i  consumer accepts the result
//   out_sum_o    sum of a+b over the batch, W+4 bits
//   out_eq_o     number of pairs in the batch with a == b
module pair_accum_stage #(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W+3:0] out_sum_o,
  output logic [3:0]   out_eq_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned CntW = (N > 1) ? $clog2(N + 1) : 1;

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  // FIFO storage and bookkeeping
  logic [W-1:0]    mem_a_q [DEPTH];
  logic [W-1:0]    mem_b_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;

  // Batch accumulation and result registers
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W+3:0]    acc_sum_q, acc_sum_d;
  logic [3:0]      acc_eq_q, acc_eq_d;
  logic [W+3:0]    res_sum_q, res_sum_d;
  logic [3:0]      res_eq_q, res_eq_d;

  logic            push, pop, fifo_empty;
  logic [W-1:0]    head_a, head_b;
  logic [W+3:0]    pair_sum, sum_nx;
  logic [3:0]      eq_nx;

  assign fifo_empty = (occ_q == '0);
  assign in_ready_o = (occ_q != OccW'(DEPTH));
  assign push       = in_valid_i && in_ready_o;

  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];
  assign pair_sum = {4'b0000, head_a} + {4'b0000, head_b};
  assign sum_nx   = acc_sum_q + pair_sum;
  assign eq_nx    = acc_eq_q + {3'b000, (head_a == head_b)};

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_sum_d = acc_sum_q;
    acc_eq_d  = acc_eq_q;
    res_sum_d = res_sum_q;
    res_eq_d  = res_eq_q;
    pop       = 1'b0;
    unique case (state_q)
      StAcc: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            // Last pair of the batch: latch the result, restart accumulation.
            res_sum_d = sum_nx;
            res_eq_d  = eq_nx;
            acc_sum_d = '0;
            acc_eq_d  = '0;
            cnt_d     = '0;
            state_d   = StDone;
          end else begin
            acc_sum_d = sum_nx;
            acc_eq_d  = eq_nx;
            cnt_d     = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          acc_sum_d = '0;
          acc_eq_d  = '0;
          state_d   = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      state_q   <= StAcc;
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_eq_q  <= '0;
      res_sum_q <= '0;
      res_eq_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_sum_q <= acc_sum_d;
      acc_eq_q  <= acc_eq_d;
      res_sum_q <= res_sum_d;
      res_eq_q  <= res_eq_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a_i;
      mem_b_q[wr_ptr_q] <= in_b_i;
    end
  end

  assign out_valid_o = (state_q == StDone);
  assign out_sum_o   = res_sum_q;
  assign out_eq_o    = res_eq_q;

  a_eq_bound : assert property (@(posedge clk) disable iff (!rst_n)
    32'(out_eq_o) <= N);
  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    32'(occ_q) <= DEPTH);
  a_valid_done : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_o |-> (state_q == StDone));
  a_sum_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_o && !out_ready_i) |=> $stable(out_sum_o));

endmodule

// File: tb/tb_pair_accum_stage.sv
// Bench for pair_accum_stage: a queue-level model checks the W=4/N=5 instance
// every cycle; directed literal checks cover every scenario plus the W=8 and
// N=1 instances.
module tb_pair_accum_stage;

  localparam int Depth = 2;
  localparam int NB    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: W=4, N=5
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, out_eq;
  logic [7:0] out_sum;
  // W=8 instance
  logic        v8 = 1'b0, rdy8, ov8, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [11:0] s8;
  logic [3:0]  e8;
  // N=1 instance
  logic       v1 = 1'b0, rdy1, ov1, or1 = 1'b0;
  logic [3:0] a1 = '0, b1 = '0, e1;
  logic [7:0] s1;

  int tests = 0;
  int fails = 0;

  pair_accum_stage #(.W(4), .N(5), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_eq_o(out_eq)
  );

  pair_accum_stage #(.W(8), .N(5)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v8), .in_ready_o(rdy8),
    .in_a_i(a8), .in_b_i(b8), .out_valid_o(ov8), .out_ready_i(or8),
    .out_sum_o(s8), .out_eq_o(e8)
  );

  pair_accum_stage #(.W(4), .N(1)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v1), .in_ready_o(rdy1),
    .in_a_i(a1), .in_b_i(b1), .out_valid_o(ov1), .out_ready_i(or1),
    .out_sum_o(s1), .out_eq_o(e1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue-level model of the main instance: pairs wait in a queue of at most
  // Depth entries; while no result is pending one pair leaves per cycle and
  // every NB-th pair closes a batch.
  initial begin
    int  qa[$];
    int  qb[$];
    int  cnt, sum, eq, xs, xe, a, b;
    bit  done, pu, po;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        qa.delete();
        qb.delete();
        cnt = 0; sum = 0; eq = 0; xs = 0; xe = 0; done = 1'b0;
      end else begin
        pu = in_valid && (qa.size() < Depth);
        po = !done && (qa.size() > 0);
        if (done && out_ready) done = 1'b0;
        if (po) begin
          a = qa.pop_front();
          b = qb.pop_front();
          sum += a + b;
          eq  += (a == b) ? 1 : 0;
          cnt++;
          if (cnt == NB) begin
            xs = sum % 256; xe = eq;
            sum = 0; eq = 0; cnt = 0;
            done = 1'b1;
          end
        end
        if (pu) begin
          qa.push_back(int'(in_a));
          qb.push_back(int'(in_b));
        end
      end
      #1;
      if (!rst_n) begin
        check("model_rst_valid", int'(out_valid), 0);
        check("model_rst_sum", int'(out_sum), 0);
        check("model_rst_eq", int'(out_eq), 0);
      end else begin
        check("model_valid", int'(out_valid), int'(done));
        check("model_in_ready", int'(in_ready), (qa.size() < Depth) ? 1 : 0);
        if (done) begin
          check("model_sum", int'(out_sum), xs);
          check("model_eq", int'(out_eq), xe);
        end
      end
    end
  end

  function automatic bit valid_of(input int sel);
    case (sel)
      1:       return ov8;
      2:       return ov1;
      default: return out_valid;
    endcase
  endfunction

  function automatic bit ready_of(input int sel);
    case (sel)
      1:       return rdy8;
      2:       return rdy1;
      default: return in_ready;
    endcase
  endfunction

  task automatic wait_ready(input int sel, input string name);
    int g = 0;
    while (!ready_of(sel) && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!ready_of(sel)) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input int sel, input string name);
    int g = 0;
    while (!valid_of(sel) && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!valid_of(sel)) check({name, "_valid_timeout"}, 0, 1);
  endtask

  // Offers a pair on the main instance and returns on the negedge after the
  // accepting edge, leaving in_valid asserted.
  task automatic push_pair(input int a, input int b);
    in_valid = 1'b1;
    in_a     = 4'(a);
    in_b     = 4'(b);
    wait_ready(0, "push");
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);

    // Width override: 5 x (200,100) on W=8
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
      wait_ready(1, "w8");
      @(negedge clk);
    end
    v8 = 1'b0;
    wait_valid(1, "w8");
    check("w8_sum", int'(s8), 1500);
    check("w8_eq", int'(e8), 0);

    // N=1: every pop is a batch
    v1 = 1'b1; a1 = 4'd7; b1 = 4'd7;
    wait_ready(2, "n1");
    @(negedge clk);
    a1 = 4'd9; b1 = 4'd0;
    wait_ready(2, "n1");
    @(negedge clk);
    v1 = 1'b0;
    wait_valid(2, "n1_first");
    check("n1_first_sum", int'(s1), 14);
    check("n1_first_eq", int'(e1), 1);
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    wait_valid(2, "n1_second");
    check("n1_second_sum", int'(s1), 9);
    check("n1_second_eq", int'(e1), 0);
    or1 = 1'b1;

    // Basic batch
    out_ready = 1'b1;
    push_pair(1, 2); push_pair(3, 3); push_pair(15, 15); push_pair(0, 0); push_pair(4, 4);
    in_valid = 1'b0;
    wait_valid(0, "basic");
    check("basic_sum", int'(out_sum), 47);
    check("basic_eq", int'(out_eq), 4);
    @(negedge clk);

    // Maximum operands at W=4
    for (int i = 0; i < 5; i++) push_pair(15, 15);
    in_valid = 1'b0;
    wait_valid(0, "max");
    check("max_sum", int'(out_sum), 150);
    check("max_eq", int'(out_eq), 5);
    @(negedge clk);

    // Back-pressure: result held while the FIFO fills behind it
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_pair(2, 1);
    repeat (3) @(negedge clk);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_valid", int'(out_valid), 1);
    check("bp_sum", int'(out_sum), 15);
    check("bp_eq", int'(out_eq), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_pair(2, 1);
    in_valid = 1'b0;
    wait_valid(0, "bp2");
    check("bp2_sum", int'(out_sum), 15);
    check("bp2_eq", int'(out_eq), 0);
    @(negedge clk);

    // Reset mid-batch
    for (int i = 0; i < 3; i++) push_pair(5, 5);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_sum", int'(out_sum), 0);
    check("rst_mid_eq", int'(out_eq), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 5; i++) push_pair(1, 1);
    in_valid = 1'b0;
    wait_valid(0, "post_rst");
    check("post_rst_sum", int'(out_sum), 10);
    check("post_rst_eq", int'(out_eq), 5);
    @(negedge clk);

    // Sparse input: one push every three cycles
    for (int i = 1; i <= 5; i++) begin
      push_pair(i, 0);
      in_valid = 1'b0;
      if (i < 5) repeat (2) @(negedge clk);
    end
    check("sparse_not_yet", int'(out_valid), 0);
    @(negedge clk);
    check("sparse_valid", int'(out_valid), 1);
    check("sparse_sum", int'(out_sum), 15);
    check("sparse_eq", int'(out_eq), 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
